// File: rtl/ipsxb_fft_test_seq_pkg.sv
// ============================================================================
// Module : ipsxb_fft_test_seq_pkg
// Brief  : Shared state encoding and sizing helper for the FFT test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ipsxb_fft_test_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ipsxb_fft_start_debounce.sv
// ============================================================================
// Module : ipsxb_fft_start_debounce
// Brief  : Start-button synchroniser with abortable hold counter; one-cycle accept strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ipsxb_fft_start_debounce
  import ipsxb_fft_test_seq_pkg::*;
#(
  parameter int DB_CNT_MAX = 2048
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_aclken,
  input  logic i_arm,
  input  logic i_start_test,
  output logic o_accept
);

  localparam int CW = clog2w(DB_CNT_MAX);

  logic [2:0]    sync_q, sync_d;
  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_lvl;
  logic          w_rise;
  logic          w_hit;

  assign w_lvl    = sync_q[1];
  assign w_rise   = sync_q[1] & ~sync_q[2];
  assign w_hit    = active_q && w_lvl && (cnt_q == CW'(DB_CNT_MAX - 1));
  assign o_accept = i_aclken & w_hit;

  always_comb begin
    sync_d   = {sync_q[1:0], i_start_test};
    active_d = active_q;
    cnt_d    = cnt_q;
    if (active_q) begin
      // A drop in the level before the count completes abandons the attempt.
      if (!w_lvl || w_hit) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (i_arm && w_rise) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (i_aclken) begin
      sync_q   <= sync_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ipsxb_fft_test_seq.sv
// ============================================================================
// Module : ipsxb_fft_test_seq
// Brief  : Onboard FFT test sequencer: start, watchdog, error latch, pass/fail counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ipsxb_fft_test_seq
  import ipsxb_fft_test_seq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DB_CNT_MAX  = 2048,
  parameter int TIMEOUT_CYC = 65536,
  parameter int GAP_CYC     = 256,
  parameter int CNT_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_aclken,
  input  logic                  i_start_test,
  input  logic                  i_mode_cont,
  input  logic [NUM_CH-1:0]     i_chk_finished,
  input  logic [NUM_CH-1:0]     i_err,
  input  logic [3*NUM_CH-1:0]   i_alm,
  output logic                  o_start_pulse,
  output logic                  o_busy,
  output logic [NUM_CH-1:0]     o_err_ch,
  output logic                  o_err,
  output logic                  o_timeout,
  output logic [CNT_W-1:0]      o_pass_cnt,
  output logic [CNT_W-1:0]      o_fail_cnt,
  output logic                  o_chk_finished
);

  localparam int WD_W    = clog2w(TIMEOUT_CYC);
  localparam int GAP_W   = clog2w(GAP_CYC);
  // Expiry fires on the cycle whose incremented count reaches TIMEOUT_CYC-1.
  localparam int WD_LAST = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;

  seq_state_e        state_q;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] err_ch_q, err_ch_d;
  logic              timeout_q;
  logic [WD_W-1:0]   wd_q;
  logic [GAP_W-1:0]  gap_q;
  logic [CNT_W-1:0]  pass_q;
  logic [CNT_W-1:0]  fail_q;
  logic              pulse_q;
  logic              busy_q;
  logic              chkfin_q;

  logic [NUM_CH-1:0] w_ch_err;
  logic [NUM_CH-1:0] w_rise;
  logic              w_all_done;
  logic              w_wd_expire;
  logic              w_arm;
  logic              w_accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ch_err[c] = i_err[c] | (|i_alm[3*c +: 3]);
  end

  always_comb begin
    w_rise      = i_chk_finished & ~prev_q;
    done_d      = done_q | w_rise;
    w_all_done  = &done_d;
    err_ch_d    = err_ch_q | w_ch_err;
    w_wd_expire = (wd_q == WD_W'(WD_LAST));
  end

  assign w_arm = (state_q == ST_IDLE);

  ipsxb_fft_start_debounce #(
    .DB_CNT_MAX (DB_CNT_MAX)
  ) u_debounce (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_aclken     (i_aclken),
    .i_arm        (w_arm),
    .i_start_test (i_start_test),
    .o_accept     (w_accept)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      done_q    <= '0;
      prev_q    <= '0;
      err_ch_q  <= '0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      gap_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      chkfin_q  <= 1'b1;
    end else if (i_aclken) begin
      busy_q   <= (state_q != ST_IDLE);
      chkfin_q <= (state_q == ST_IDLE) || (state_q == ST_GAP) ||
                  ((state_q == ST_RUN) && (&done_q));
      pulse_q  <= 1'b0;
      prev_q   <= i_chk_finished;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q <= ST_START;
            pulse_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q   <= ST_RUN;
          prev_q    <= '0;
          done_q    <= '0;
          err_ch_q  <= '0;
          timeout_q <= 1'b0;
          wd_q      <= '0;
        end
        ST_RUN: begin
          done_q   <= done_d;
          err_ch_q <= err_ch_d;
          wd_q     <= wd_q + 1'b1;
          // Completion outranks a watchdog expiry landing on the same cycle.
          if (w_all_done || w_wd_expire) begin
            if (!w_all_done) timeout_q <= 1'b1;
            if (!w_all_done || (|err_ch_d)) begin
              if (fail_q != '1) fail_q <= fail_q + 1'b1;
            end else begin
              if (pass_q != '1) pass_q <= pass_q + 1'b1;
            end
            state_q <= i_mode_cont ? ST_GAP : ST_IDLE;
            gap_q   <= '0;
          end
        end
        ST_GAP: begin
          if (!i_mode_cont) begin
            state_q <= ST_IDLE;
          end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            state_q <= ST_START;
            pulse_q <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_start_pulse  = pulse_q;
  assign o_busy         = busy_q;
  assign o_err_ch       = err_ch_q;
  assign o_err          = (|err_ch_q) | timeout_q;
  assign o_timeout      = timeout_q;
  assign o_pass_cnt     = pass_q;
  assign o_fail_cnt     = fail_q;
  assign o_chk_finished = chkfin_q;

endmodule

`default_nettype wire

// File: tb/tb_ipsxb_fft_test_seq.sv
// ============================================================================
// Module : tb_ipsxb_fft_test_seq
// Brief  : Directed table-driven bench for the FFT test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ipsxb_fft_test_seq;

  localparam int NUM_CH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, aclken, start, mode;
  logic [1:0]  fin, err;
  logic [5:0]  alm;

  logic        pulse, busy, o_err, tmo, chkfin;
  logic [1:0]  err_ch;
  logic [15:0] pass_cnt, fail_cnt;
  logic        pulse2, busy2, o_err2, tmo2, chkfin2;
  logic [1:0]  err_ch2;
  logic [1:0]  pass_cnt2, fail_cnt2;

  ipsxb_fft_test_seq #(
    .NUM_CH(NUM_CH), .DB_CNT_MAX(16), .TIMEOUT_CYC(64), .GAP_CYC(8), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_aclken(aclken), .i_start_test(start),
    .i_mode_cont(mode), .i_chk_finished(fin), .i_err(err), .i_alm(alm),
    .o_start_pulse(pulse), .o_busy(busy), .o_err_ch(err_ch), .o_err(o_err),
    .o_timeout(tmo), .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt),
    .o_chk_finished(chkfin)
  );

  ipsxb_fft_test_seq #(
    .NUM_CH(NUM_CH), .DB_CNT_MAX(16), .TIMEOUT_CYC(64), .GAP_CYC(8), .CNT_W(2)
  ) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_aclken(aclken), .i_start_test(start),
    .i_mode_cont(mode), .i_chk_finished(fin), .i_err(err), .i_alm(alm),
    .o_start_pulse(pulse2), .o_busy(busy2), .o_err_ch(err_ch2), .o_err(o_err2),
    .o_timeout(tmo2), .o_pass_cnt(pass_cnt2), .o_fail_cnt(fail_cnt2),
    .o_chk_finished(chkfin2)
  );

  typedef struct {
    int         f0;
    int         f1;
    int         ev_k;
    logic [1:0] ev_err;
    logic [5:0] ev_alm;
    int         end_k;
    logic [1:0] x_err_ch;
    logic       x_tmo;
    int         dpass;
    int         dfail;
  } vec_t;

  vec_t tbl [6];

  int  checks = 0;
  int  failures = 0;
  int  exp_pass = 0;
  int  exp_fail = 0;
  bit  div3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled cycle: a single clock, or one enabled clock plus two stalled ones.
  task automatic adv();
    aclken = 1'b1;
    tick();
    if (div3) begin
      aclken = 1'b0;
      tick();
      tick();
      aclken = 1'b1;
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_pass"}, 32'(pass_cnt), exp_pass);
    check({name, "_fail"}, 32'(fail_cnt), exp_fail);
    check({name, "_pass_sat"}, 32'(pass_cnt2), sat3(exp_pass));
    check({name, "_fail_sat"}, 32'(fail_cnt2), sat3(exp_fail));
  endtask

  task automatic wait_pulse(output int lat, input int budget);
    lat = 0;
    do begin
      adv();
      lat++;
    end while (pulse !== 1'b1 && lat < budget);
  endtask

  task automatic do_run(input vec_t v);
    int lat;
    int pulses;
    start = 1'b1;
    wait_pulse(lat, 40);
    check("db_latency", lat, 19);
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= v.end_k + 1; k++) begin
      fin[0] = (v.f0 != 0) && (k >= v.f0);
      fin[1] = (v.f1 != 0) && (k >= v.f1);
      err    = (k == v.ev_k) ? v.ev_err : 2'b00;
      alm    = (k == v.ev_k) ? v.ev_alm : 6'd0;
      adv();
      if (pulse) pulses++;
      if (k == 1) begin
        check("start_busy", busy, 1);
        check("start_err_clr", err_ch, 0);
        check("start_tmo_clr", tmo, 0);
        check("start_chkfin", chkfin, 0);
      end
      if (k == v.end_k - 1) begin
        check("pre_tmo", tmo, 0);
        check_counts("pre_result");
      end
      if (k == v.end_k) begin
        exp_pass += v.dpass;
        exp_fail += v.dfail;
        check_counts("result");
        check("result_err_ch", err_ch, v.x_err_ch);
        check("result_tmo", tmo, v.x_tmo);
        check("result_o_err", o_err, (|v.x_err_ch) | v.x_tmo);
      end
      if (k == v.end_k + 1) begin
        check("post_busy", busy, 0);
        check("post_chkfin", chkfin, 1);
      end
    end
    check("extra_pulse", pulses, 0);
    fin = 2'b00; err = 2'b00; alm = 6'd0;
    repeat (3) adv();
  endtask

  initial begin
    int lat, pulses, busy_seen, gap, c0;
    rst = 1'b1; aclken = 1'b1; start = 1'b0; mode = 1'b0;
    fin = 2'b00; err = 2'b00; alm = 6'd0;

    //                f0  f1  ev  ev_err ev_alm     end  err_ch tmo pass fail
    tbl[0] = '{30, 35, 0,  2'b00, 6'b000_000, 35, 2'b00, 1'b0, 1, 0};
    tbl[1] = '{30, 35, 10, 2'b10, 6'b000_000, 35, 2'b10, 1'b0, 0, 1};
    tbl[2] = '{20, 0,  0,  2'b00, 6'b000_000, 64, 2'b00, 1'b1, 0, 1};
    tbl[3] = '{12, 18, 5,  2'b00, 6'b000_100, 18, 2'b01, 1'b0, 0, 1};
    tbl[4] = '{40, 64, 0,  2'b00, 6'b000_000, 64, 2'b00, 1'b0, 1, 0};
    tbl[5] = '{25, 25, 7,  2'b00, 6'b010_000, 25, 2'b10, 1'b0, 0, 1};

    tick(); tick();
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_chkfin", chkfin, 1);
    check("rst_o_err", o_err, 0);
    check_counts("rst");
    rst = 1'b0;
    tick();

    // Errors outside RUN are not latched.
    err = 2'b11; alm = 6'b111_111;
    repeat (3) adv();
    check("idle_err_ignored", err_ch, 0);
    check("idle_o_err", o_err, 0);
    err = 2'b00; alm = 6'd0;

    // Button released before the hold count completes.
    start = 1'b1;
    repeat (10) adv();
    start = 1'b0;
    pulses = 0; busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      adv();
      if (pulse) pulses++;
      if (busy) busy_seen++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_no_busy", busy_seen, 0);

    for (int i = 0; i < 6; i++) do_run(tbl[i]);

    // Continuous mode: three clean runs, then mode dropped during the gap.
    mode = 1'b1;
    start = 1'b1;
    wait_pulse(lat, 40);
    check("cont_db_latency", lat, 19);
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 36; k++) begin
        fin[0] = (k >= 30) && (k <= 35);
        fin[1] = (k == 35);
        if (r == 2 && k == 36) mode = 1'b0;
        adv();
        if (k == 35) begin
          exp_pass++;
          check_counts("cont");
        end
        if (k == 36 && r < 2) check("cont_gap_busy", busy, 1);
      end
      fin = 2'b00;
      if (r < 2) begin
        gap = 36;
        while (pulse !== 1'b1 && gap < 60) begin
          adv();
          gap++;
        end
        check("cont_spacing", gap, 43);
      end
    end
    adv();
    check("cont_stop_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      adv();
      if (pulse) pulses++;
    end
    check("cont_stop_no_pulse", pulses, 0);

    // Clock enable 1-in-3: timeout run in enabled cycles, then clocks scale by 3.
    div3 = 1'b1;
    start = 1'b1;
    wait_pulse(lat, 40);
    check("div3_db_latency", lat, 19);
    start = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 64; k++) begin
      fin[0] = (k >= 20);
      fin[1] = 1'b0;
      adv();
      if (k == 63) check("div3_pre_tmo", tmo, 0);
      if (k == 64) begin
        exp_fail++;
        check("div3_tmo", tmo, 1);
        check("div3_tmo_clocks", cyc - c0, 192);
        check_counts("div3");
      end
    end
    fin = 2'b00;
    repeat (3) adv();
    div3 = 1'b0;
    aclken = 1'b1;

    // Reset in the middle of a run.
    start = 1'b1;
    wait_pulse(lat, 40);
    check("rr_db_latency", lat, 19);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      err = (k == 5) ? 2'b01 : 2'b00;
      adv();
    end
    check("rr_err_before", err_ch, 1);
    rst = 1'b1;
    tick();
    exp_pass = 0;
    exp_fail = 0;
    check("rr_busy", busy, 0);
    check("rr_err_ch", err_ch, 0);
    check("rr_o_err", o_err, 0);
    check("rr_pulse", pulse, 0);
    check("rr_chkfin", chkfin, 1);
    check_counts("rr");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      adv();
      if (pulse) pulses++;
    end
    check("rr_no_pulse", pulses, 0);
    check("rr_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", $time);
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire
